shared_reg_arbiter: RTL
=======================

Name: shared_reg_arbiter

Overview:
- Round-robin write arbiter for a single shared WIDTH-bit storage register with true (q) and complement (qn) outputs.
- Up to NUM_REQ requesters compete to load the register. The block grants one requester at a time, commits its data and acknowledges it.
- Sits between multiple producer blocks and the shared reset-able register datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data/register width in bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  NUM_REQ  per-requester write request; level, held until ack or abandoned.
- wdata  input  NUM_REQ*WIDTH  flattened write data; requester i owns bits [i*WIDTH +: WIDTH].
- gnt  output  NUM_REQ  registered one-hot grant.
- ack  output  1  one-cycle pulse: the granted write committed.
- owner  output  3  index of the last committed requester.
- busy  output  1  high while in GRANT state.
- q  output  WIDTH  shared register value.
- qn  output  WIDTH  bitwise complement of q, always ~q.

Behaviour:
- Reset: sampled on clk rising edge when reset_n=0. Overrides everything, including a write in progress.
- Reset values: q=0, qn=all ones, gnt=0, ack=0, owner=0, busy=0, round-robin pointer=0, state=IDLE.
- FSM has two states: IDLE and GRANT.
- IDLE with req==0: stay in IDLE, all outputs hold, ack=0.
- IDLE with req!=0:
  - Winner = first requester with req high, searching from pointer upward and wrapping NUM_REQ-1 -> 0.
  - Next cycle: gnt=onehot(winner), busy=1, state=GRANT.
- GRANT with req[winner]=1:
  - At the edge: q<=wdata slice of winner, ack<=1 for exactly one cycle, owner<=winner, gnt<=0, busy<=0.
  - pointer<=(winner+1) mod NUM_REQ; state=IDLE.
- GRANT with req[winner]=0 (abandoned): no write, no ack, q, owner and pointer unchanged, gnt<=0, state=IDLE.
- Latency and throughput:
  - Request seen in IDLE -> gnt next cycle -> q and ack updated on the following cycle (2 cycles).
  - Maximum throughput is one commit per 2 cycles.
  - The ack cycle is an IDLE cycle, so a new arbitration may start in it.
- Requester contract:
  - Requester must keep wdata stable while its gnt is high.
  - Requester must drop req (or present new data) in the cycle it sees ack.
  - A req still high during the ack cycle is treated as a new request.
- Requests from non-winners during GRANT are ignored; they are re-evaluated in IDLE.
- The pointer advances only on a commit, which guarantees starvation freedom among continuously requesting masters.
- qn is derived combinationally from q; the two never disagree.
- owner is zero-extended to 3 bits.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: winner = lowest-index requester with req high; pointer is unused and stays 0; starvation is permitted by design.
- Undefined (default): round-robin as above.
- All other timing and handshake rules are identical in both builds.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with req=4'b1111 -> gnt=0, ack=0, q=8'h00, qn=8'hFF throughout.
- Single write: after reset, req=4'b0100 with wdata[2]=8'hAA -> gnt=4'b0100 one cycle later; next cycle q=8'hAA, qn=8'h55, ack=1 for one cycle, owner=2.
- Round-robin: req=4'b1111 held, wdata[i]=8'h10+i, default build -> commit order 0,1,2,3,0 with q=8'h10,8'h11,8'h12,8'h13,8'h10; ack every 2nd cycle.
- Abandon: grant requester 1, then drop req[1] during GRANT -> no ack, q unchanged, pointer unchanged; re-request of 1 with nothing higher in round-robin order regrants 1.
- Reset mid-operation: assert reset_n=0 while busy=1 with gnt=4'b0010 -> next cycle gnt=0, busy=0, q=8'h00, no ack.
- Fixed priority (ARB_FIXED_PRIO_EN defined): req=4'b1010 held -> requester 1 wins every arbitration and requester 3 is never granted while req[1]=1.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Round-robin write arbiter for one shared WIDTH-bit register (q/qn); grant is registered, commit + ack one cycle later.
// Define ARB_FIXED_PRIO_EN to select lowest-index-wins priority instead of round-robin.
module shared_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   wdata,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       ack,
    output logic [2:0]                 owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qn
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_REQ - 1);

    typedef enum logic {S_IDLE, S_GRANT} state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic                 ack_q, ack_d;
    logic [2:0]           owner_q, owner_d;
    logic                 busy_q, busy_d;
    logic [WIDTH-1:0]     data_q, data_d;
`ifndef ARB_FIXED_PRIO_EN
    logic [IW-1:0]        ptr_q, ptr_d;
`endif
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [WIDTH-1:0]     wd [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign wd[i] = wdata[i*WIDTH +: WIDTH];
    end

    // Scan requesters starting at the search origin; the first one found wins.
    always_comb begin : arb
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
            if (!pick_vld && req[idx[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = 1'b0;
        owner_d = owner_q;
        busy_d  = busy_q;
        data_d  = data_q;
`ifndef ARB_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    win_d   = pick;
                    gnt_d   = NUM_REQ'(1) << pick;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt_d   = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
                // A dropped request abandons the grant without touching q, owner or pointer.
                if (req[win_q]) begin
                    data_d  = wd[win_q];
                    ack_d   = 1'b1;
                    owner_d = 3'(win_q);
`ifndef ARB_FIXED_PRIO_EN
                    ptr_d   = (win_q == LAST) ? '0 : win_q + IW'(1);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= 1'b0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
`ifndef ARB_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign ack   = ack_q;
    assign owner = owner_q;
    assign busy  = busy_q;
    assign q     = data_q;
    assign qn    = ~data_q;

endmodule
